muldiv_issue_ctrl: RTL and testbench
====================================

// Module: muldiv_issue_ctrl
// PURPOSE
//  Issue/hazard controller between the ID stage and the HI/LO multiply-divide unit.
//  Decodes ID-stage mul/div/move-to-HI/LO/madd/move-from-HI/LO requests.
//  Drives the unit's start/we/HiLo/MulOp/operand inputs.
//  Stalls the pipeline while the unit is busy, and counts stall cycles for perf debug.
// PARAMETERS
//  MUL_CYCLES  5   unit latency (start->HI/LO valid) for mult/multu; must match unit
//  DIV_CYCLES  10  unit latency for div/divu; must match unit
//  CNT_W       4   width of shadow latency counter; must hold DIV_CYCLES+1
// PORTS
//  clk         in   1   clock
//  reset       in   1   synchronous, active-high reset
//  id_valid    in   1   ID stage holds a valid instruction
//  id_op       in   4   md_op_e code (see STRUCTURE)
//  id_rs       in   32  rs operand value (already forwarded)
//  id_rt       in   32  rt operand value (already forwarded)
//  ex_flush    in   1   pipeline flush; cancels acceptance in this cycle
//  md_busy     in   1   busy from mul/div unit
//  md_start    out  1   one-cycle start pulse to unit
//  md_we       out  1   one-cycle write pulse to unit
//  md_hilo     out  2   01=write HI, 00=write LO, 10=madd
//  md_mulop    out  2   00 multu, 01 mult, 10 divu, 11 div
//  md_a        out  32  operand a to unit (registered)
//  md_b        out  32  operand b to unit (registered)
//  stall       out  1   freeze IF/ID; combinational
//  stall_cnt   out  32  saturating count of cycles with stall=1
// BEHAVIOUR
//  - Classes:
//    - ARITH = MULTU/MULT/DIVU/DIV.
//    - WRITE = MTHI/MTLO/MADD.
//    - READ = MFHI/MFLO.
//    - NONE: never stalls, never issues.
//  - busy_int = (shadow_cnt != 0) | md_start | md_busy.
//  - stall = id_valid & (class != NONE) & busy_int & ~ex_flush.
//  - Accept when id_valid & class in {ARITH, WRITE} & ~busy_int & ~ex_flush.
//    The ID instruction is consumed in that cycle.
//  - ARITH accept in cycle T:
//    - T+1: md_start=1; md_mulop from op; md_a=rs; md_b=rt.
//    - End of T: shadow_cnt loads MUL_CYCLES+1 or DIV_CYCLES+1.
//  - WRITE accept in cycle T:
//    - T+1: md_we=1; md_hilo from op; md_a=rs; md_b=rt.
//    - shadow_cnt loads 1.
//  - READ never issues. Stalls until busy_int=0, then passes; the pipeline reads HI/LO directly.
//  - shadow_cnt decrements by 1 per cycle while nonzero; it never wraps below 0.
//  - md_start and md_we are never high together, and are never high on consecutive accepts.
//  - md_mulop/md_hilo/md_a/md_b hold their last value when no pulse is present.
//  - ex_flush:
//    - Suppresses acceptance and stall in the same cycle.
//    - Does NOT cancel an op already issued; HI/LO commit is architectural.
//  - stall_cnt increments each stall cycle and saturates at 32'hFFFF_FFFF.
//  - Reset (any cycle, including mid-op):
//    - md_start=0, md_we=0, md_hilo=0, md_mulop=0, md_a=0, md_b=0.
//    - shadow_cnt=0, stall_cnt=0.
//    - stall then follows md_busy only; the unit is reset by the same signal.
//  - Illegal id_op codes (10..15) are treated as NONE.
// STRUCTURE
//  - Package md_pkg:
//    - md_op_e: NONE=0, MULTU=1, MULT=2, DIVU=3, DIV=4, MTHI=5, MTLO=6, MADD=7, MFHI=8, MFLO=9.
//    - HILO_LO=2'b00, HILO_HI=2'b01, HILO_MADD=2'b10.
//    - MULOP_* constants.
//  - One sub-module, md_latency_cnt: loadable down-counter with nonzero flag; used for shadow_cnt.
//  - All other logic stays flat in this module.
// TESTING
//  - MULT with rs=3, rt=-2 at T: md_start=1 and md_mulop=01 at T+1, md_a=3, md_b=FFFFFFFE.
//    A following MFLO stalls until busy_int=0, then LO=FFFFFFFA, HI=FFFFFFFF.
//  - DIVU with rs=100, rt=7, then an immediate MULTU: MULTU stalls >= DIV_CYCLES+1 cycles.
//    It issues only after the DIVU result (LO=14, HI=2) is written.
//  - MTHI rs=0xDEAD0000 while idle: md_we=1 and md_hilo=01 one cycle later, with no stall.
//    A following MFHI stalls 1 cycle, then reads 0xDEAD0000.
//  - DIV issued with ex_flush=1 in its ID cycle: no md_start, shadow_cnt stays 0.
//    A flush one cycle after issue does not stop the DIV; HI/LO still update.
//  - Reset asserted 3 cycles into DIV: all outputs zero next cycle and shadow_cnt=0.
//    A MULT issued right after reset starts normally.
//  - Back-to-back MFLO with 8 stall cycles: stall_cnt=8.
//    Forced stall_cnt=FFFFFFFE plus 3 stall cycles: stall_cnt holds FFFFFFFF.

Source files
------------

// File: rtl/md_pkg.sv
// Shared opcode, class and unit-encoding definitions for the HI/LO
// multiply-divide issue path.
package md_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULTU = 4'd1,
    OP_MULT  = 4'd2,
    OP_DIVU  = 4'd3,
    OP_DIV   = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MFHI  = 4'd8,
    OP_MFLO  = 4'd9
  } md_op_e;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_ARITH,
    CLS_WRITE,
    CLS_READ
  } md_cls_e;

  localparam logic [1:0] HILO_LO   = 2'b00;
  localparam logic [1:0] HILO_HI   = 2'b01;
  localparam logic [1:0] HILO_MADD = 2'b10;

  localparam logic [1:0] MULOP_MULTU = 2'b00;
  localparam logic [1:0] MULOP_MULT  = 2'b01;
  localparam logic [1:0] MULOP_DIVU  = 2'b10;
  localparam logic [1:0] MULOP_DIV   = 2'b11;

  // Codes 10..15 fall through to NONE so they never stall or issue.
  function automatic md_cls_e op_class(input logic [3:0] op);
    md_cls_e cls;
    case (op)
      OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: cls = CLS_ARITH;
      OP_MTHI, OP_MTLO, OP_MADD:          cls = CLS_WRITE;
      OP_MFHI, OP_MFLO:                   cls = CLS_READ;
      default:                            cls = CLS_NONE;
    endcase
    return cls;
  endfunction

  function automatic logic [1:0] mulop_of(input logic [3:0] op);
    logic [1:0] m;
    case (op)
      OP_MULT: m = MULOP_MULT;
      OP_DIVU: m = MULOP_DIVU;
      OP_DIV:  m = MULOP_DIV;
      default: m = MULOP_MULTU;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] hilo_of(input logic [3:0] op);
    logic [1:0] h;
    case (op)
      OP_MTHI: h = HILO_HI;
      OP_MADD: h = HILO_MADD;
      default: h = HILO_LO;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/md_latency_cnt.sv
// Loadable down-counter shadowing the unit's latency; stops at zero and
// reports whether it is still counting.
module md_latency_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         nz
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign nz = (cnt_q != '0);

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// Issue/hazard control between ID and the HI/LO multiply-divide unit:
// decodes requests, pulses start/we with registered operands, stalls ID.
module muldiv_issue_ctrl
  import md_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [3:0]  id_op,
  input  logic [31:0] id_rs,
  input  logic [31:0] id_rt,
  input  logic        ex_flush,
  input  logic        md_busy,
  output logic        md_start,
  output logic        md_we,
  output logic [1:0]  md_hilo,
  output logic [1:0]  md_mulop,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        stall,
  output logic [31:0] stall_cnt
);

  // Shadow spans the start cycle plus the full unit latency.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(1);

  md_cls_e          id_cls;
  logic             busy_int, accept, is_arith, is_write;
  logic             shadow_nz, shadow_load;
  logic [CNT_W-1:0] shadow_val;

  logic        md_start_q, md_start_d;
  logic        md_we_q, md_we_d;
  logic [1:0]  md_hilo_q, md_hilo_d;
  logic [1:0]  md_mulop_q, md_mulop_d;
  logic [31:0] md_a_q, md_a_d;
  logic [31:0] md_b_q, md_b_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    id_cls   = op_class(id_op);
    is_arith = (id_cls == CLS_ARITH);
    is_write = (id_cls == CLS_WRITE);
    busy_int = shadow_nz | md_start_q | md_busy;
    stall    = id_valid & (id_cls != CLS_NONE) & busy_int & ~ex_flush;
    accept   = id_valid & (is_arith | is_write) & ~busy_int & ~ex_flush;

    md_start_d  = 1'b0;
    md_we_d     = 1'b0;
    md_hilo_d   = md_hilo_q;
    md_mulop_d  = md_mulop_q;
    md_a_d      = md_a_q;
    md_b_d      = md_b_q;
    shadow_load = 1'b0;
    shadow_val  = WR_LOAD;

    if (accept) begin
      md_a_d      = id_rs;
      md_b_d      = id_rt;
      shadow_load = 1'b1;
      if (is_arith) begin
        md_start_d = 1'b1;
        md_mulop_d = mulop_of(id_op);
        shadow_val = (id_op == OP_DIVU || id_op == OP_DIV) ? DIV_LOAD : MUL_LOAD;
      end else begin
        md_we_d    = 1'b1;
        md_hilo_d  = hilo_of(id_op);
      end
    end

    stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_start_q  <= 1'b0;
      md_we_q     <= 1'b0;
      md_hilo_q   <= '0;
      md_mulop_q  <= '0;
      md_a_q      <= '0;
      md_b_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_start_q  <= md_start_d;
      md_we_q     <= md_we_d;
      md_hilo_q   <= md_hilo_d;
      md_mulop_q  <= md_mulop_d;
      md_a_q      <= md_a_d;
      md_b_q      <= md_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  md_latency_cnt #(.W(CNT_W)) u_shadow (
    .clk      (clk),
    .reset    (reset),
    .load     (shadow_load),
    .load_val (shadow_val),
    .nz       (shadow_nz)
  );

  assign md_start  = md_start_q;
  assign md_we     = md_we_q;
  assign md_hilo   = md_hilo_q;
  assign md_mulop  = md_mulop_q;
  assign md_a      = md_a_q;
  assign md_b      = md_b_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed plus random bench for muldiv_issue_ctrl, with a timestamp-based
// hazard model and a behavioural HI/LO unit that reacts to the DUT's pulses.
module tb_muldiv_issue_ctrl;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  localparam logic [3:0] MULTU = 4'd1, MULT = 4'd2, DIVU = 4'd3, DIV = 4'd4;
  localparam logic [3:0] MTHI = 4'd5, MTLO = 4'd6, MADD = 4'd7, MFHI = 4'd8, MFLO = 4'd9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [3:0]  id_op = '0;
  logic [31:0] id_rs = '0, id_rt = '0;
  logic        ex_flush = 1'b0;
  logic        md_busy = 1'b0;
  logic        md_start, md_we, stall;
  logic [1:0]  md_hilo, md_mulop;
  logic [31:0] md_a, md_b, stall_cnt;

  muldiv_issue_ctrl #(.MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_op(id_op),
    .id_rs(id_rs), .id_rt(id_rt), .ex_flush(ex_flush), .md_busy(md_busy),
    .md_start(md_start), .md_we(md_we), .md_hilo(md_hilo), .md_mulop(md_mulop),
    .md_a(md_a), .md_b(md_b), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Hazard model: the unit is free once the cycle index reaches free_at.
  longint      cyc = 0;
  longint      free_at = 0;
  logic        e_start = 0, e_we = 0, e_stall = 0;
  logic [1:0]  e_hilo = 0, e_mulop = 0;
  logic [31:0] e_a = 0, e_b = 0, e_sc = 0;

  // Behavioural multiply-divide unit.
  logic [31:0] hi = 0, lo = 0, p_hi = 0, p_lo = 0;
  int          ucnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int cls_of(input logic [3:0] op);
    if (op >= 1 && op <= 4) return 1;
    if (op >= 5 && op <= 7) return 2;
    if (op == 8 || op == 9) return 3;
    return 0;
  endfunction

  function automatic logic [63:0] sprod(input logic [31:0] a, input logic [31:0] b);
    return {{32{a[31]}}, a} * {{32{b[31]}}, b};
  endfunction

  task automatic unit_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] ma, mb, q, r;
    case (op)
      2'b00: begin p = {32'b0, a} * {32'b0, b}; p_hi = p[63:32]; p_lo = p[31:0]; ucnt = MUL_LAT; end
      2'b01: begin p = sprod(a, b); p_hi = p[63:32]; p_lo = p[31:0]; ucnt = MUL_LAT; end
      2'b10: begin
        if (b == 0) begin p_lo = '1; p_hi = a; end
        else begin p_lo = a / b; p_hi = a % b; end
        ucnt = DIV_LAT;
      end
      default: begin
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : b;
        if (b == 0) begin q = '1; r = a; end
        else begin
          q = ma / mb; r = ma % mb;
          if (a[31] ^ b[31]) q = -q;
          if (a[31]) r = -r;
        end
        p_lo = q; p_hi = r; ucnt = DIV_LAT;
      end
    endcase
    md_busy = 1'b1;
  endtask

  // One clock cycle, entered and left 1 time unit after a rising edge.
  task automatic step(input logic v, input logic [3:0] op, input logic [31:0] rs,
                      input logic [31:0] rt, input logic fl, input logic rst);
    logic        busy, acc, u_start, u_we;
    logic [1:0]  u_hilo, u_mulop;
    logic [31:0] u_a, u_b;
    logic [63:0] acc64;
    int          c;
    id_valid = v; id_op = op; id_rs = rs; id_rt = rt; ex_flush = fl; reset = rst;
    c = cls_of(op);
    #3;
    busy    = (cyc < free_at) || md_busy;
    e_stall = v && c != 0 && busy && !fl;
    acc     = v && (c == 1 || c == 2) && !busy && !fl;
    chk("stall", stall, e_stall);
    u_start = md_start; u_we = md_we; u_hilo = md_hilo; u_mulop = md_mulop;
    u_a = md_a; u_b = md_b;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      e_start = 0; e_we = 0; e_hilo = 0; e_mulop = 0; e_a = 0; e_b = 0; e_sc = 0;
      free_at = 0; ucnt = 0; md_busy = 1'b0;
    end else begin
      e_start = acc && c == 1;
      e_we    = acc && c == 2;
      if (acc) begin
        e_a = rs; e_b = rt;
        if (c == 1) begin
          e_mulop = op[1:0] - 2'd1;
          if (op == DIV) e_mulop = 2'b11;
          free_at = cyc + ((op == DIVU || op == DIV) ? DIV_LAT : MUL_LAT) + 1;
        end else begin
          e_hilo  = (op == MTHI) ? 2'b01 : (op == MTLO) ? 2'b00 : 2'b10;
          free_at = cyc + 1;
        end
      end
      if (e_stall && e_sc != 32'hFFFF_FFFF) e_sc = e_sc + 1;
      if (ucnt > 0) begin
        ucnt--;
        if (ucnt == 0) begin hi = p_hi; lo = p_lo; md_busy = 1'b0; end
      end
      if (u_start) unit_start(u_mulop, u_a, u_b);
      if (u_we) begin
        case (u_hilo)
          2'b01: hi = u_a;
          2'b00: lo = u_a;
          default: begin acc64 = {hi, lo} + sprod(u_a, u_b); hi = acc64[63:32]; lo = acc64[31:0]; end
        endcase
      end
    end
    chk("md_start", md_start, e_start);
    chk("md_we", md_we, e_we);
    chk("md_hilo", md_hilo, e_hilo);
    chk("md_mulop", md_mulop, e_mulop);
    chk("md_a", md_a, e_a);
    chk("md_b", md_b, e_b);
    chk("stall_cnt", stall_cnt, e_sc);
  endtask

  // Hold an instruction in ID until it is no longer stalled.
  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       output int stalls);
    stalls = 0;
    do begin
      step(1'b1, op, rs, rt, 1'b0, 1'b0);
      if (e_stall) stalls++;
    end while (e_stall && stalls < 100);
    if (stalls >= 100) chk("issue_bound", stall, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int s;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_shadow", 32'(dut.u_shadow.cnt_q), 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_md_a", md_a, 32'd0);
    idle(2);

    // MULT 3 * -2, then MFLO waits for the product
    issue(MULT, 32'd3, 32'hFFFF_FFFE, s);
    chk("mult_nostall", s, 0);
    chk("mult_start", md_start, 1'b1);
    chk("mult_mulop", md_mulop, 2'b01);
    chk("mult_a", md_a, 32'd3);
    chk("mult_b", md_b, 32'hFFFF_FFFE);
    issue(MFLO, 0, 0, s);
    chk("mflo_stalls", s, MUL_LAT + 1);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    chk("mult_hi", hi, 32'hFFFF_FFFF);

    // DIVU then MULTU back-to-back
    idle(1);
    issue(DIVU, 32'd100, 32'd7, s);
    issue(MULTU, 32'd5, 32'd6, s);
    chk("multu_stalls_ge", (s >= DIV_LAT + 1), 1'b1);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    chk("multu_start", md_start, 1'b1);
    idle(8);

    // MTHI while idle, MFHI follows
    issue(MTHI, 32'hDEAD_0000, 32'd0, s);
    chk("mthi_nostall", s, 0);
    chk("mthi_we", md_we, 1'b1);
    chk("mthi_hilo", md_hilo, 2'b01);
    issue(MFHI, 0, 0, s);
    chk("mfhi_stalls", s, 1);
    chk("mfhi_hi", hi, 32'hDEAD_0000);

    // Flush in the ID cycle cancels; flush after issue does not
    idle(1);
    step(1, DIV, 32'hFFFF_FF9C, 32'd7, 1, 0);
    chk("flush_no_start", md_start, 1'b0);
    chk("flush_shadow", 32'(dut.u_shadow.cnt_q), 32'd0);
    issue(DIV, 32'hFFFF_FF9C, 32'd7, s);
    chk("div_start", md_start, 1'b1);
    step(0, 0, 0, 0, 1, 0);
    idle(12);
    chk("div_lo", lo, 32'hFFFF_FFF2);
    chk("div_hi", hi, 32'hFFFF_FFFE);

    // Reset three cycles into a DIV
    issue(DIV, 32'd50, 32'd3, s);
    idle(2);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_mid_start", md_start, 1'b0);
    chk("rst_mid_a", md_a, 32'd0);
    chk("rst_mid_b", md_b, 32'd0);
    chk("rst_mid_shadow", 32'(dut.u_shadow.cnt_q), 32'd0);
    issue(MULT, 32'd4, 32'd5, s);
    chk("post_rst_nostall", s, 0);
    chk("post_rst_start", md_start, 1'b1);

    // Stall counting: 6 + 1 + 1 stall cycles
    issue(MFLO, 0, 0, s);
    issue(MTLO, 32'd9, 0, s);
    issue(MFLO, 0, 0, s);
    issue(MTLO, 32'd10, 0, s);
    issue(MFLO, 0, 0, s);
    chk("stall_cnt_8", stall_cnt, 32'd8);
    chk("mflo_after_mtlo", lo, 32'd10);

    // Saturation from FFFFFFFE
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    e_sc = 32'hFFFF_FFFE;
    issue(MULTU, 32'd2, 32'd2, s);
    issue(MFLO, 0, 0, s);
    chk("stall_cnt_sat", stall_cnt, 32'hFFFF_FFFF);

    // Random traffic, including illegal codes, flushes and resets
    for (int i = 0; i < 600; i++) begin
      logic rv, rf, rr;
      logic [3:0] rop;
      rr  = ($urandom_range(0, 63) == 0);
      rv  = ($urandom_range(0, 3) != 0);
      rf  = ($urandom_range(0, 7) == 0);
      rop = 4'($urandom_range(0, 15));
      step(rv, rop, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, rf, rr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
